fc_act_stream: RTL and testbench
================================

# fc_act_stream

Pipelined, handshaked activation stage for the fully-connected datapath, generalising the combinational ReLU/HardTanh clip. Each beat takes `LANES` offset-binary accumulator sums, removes the `DIM_IN` zero point, applies a per-beat arithmetic right shift, and clips to `INWD`-bit offset-binary using a per-beat activation mode. It sits between the accumulator array and the output buffer. It sequences `FOLD` beats per output vector and flags the last beat of each vector.

## Interface
- `INWD`, 8: activation/output width, offset-binary; `HALF` = 2^(INWD-1) is the zero code.
- `DIM_IN`, 4: fan-in; sets the input zero point `ZP` = DIM_IN*HALF. Need not be a power of two.
- `LOG_DIM_IN`, 2: ceil(log2(DIM_IN)); input width `IW` = INWD+LOG_DIM_IN.
- `LANES`, 4: channels per beat (DIM_OUT/FOLD).
- `FOLD`, 2: beats per output vector, ≥1.
- `SHW`, 3: width of the shift field.
- `CNTW`, 16: saturation counter width.
- `clk` in 1: clock. Reset is synchronous and active-high; one clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_data` in LANES*IW: lane j at bits [j*IW +: IW], unsigned.
- `in_mode` in 1: 0 = ReLU, 1 = HardTanh; sampled with the beat.
- `in_shift` in SHW: arithmetic right shift applied after zero-point removal; sampled with the beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out LANES*INWD: clipped lanes, same packing.
- `out_last` out 1: high on beat FOLD-1 of each vector.
- `clr_cnt` in 1: clears the saturation counters.
- `sat_lo_cnt` out CNTW: lanes clipped low (compiled-in feature only).
- `sat_hi_cnt` out CNTW: lanes clipped high (compiled-in feature only).

## Operation
- **Stage 1 (S1) register:**
  - s = signed(in_data[j]) − ZP, computed at width IW+1 signed.
  - t = s >>> in_shift, arithmetic (floor).
  - `mode` and a lane-wise t are registered alongside.
- **Stage 2 (S2) register, per lane:**
  - ReLU:
    - t < 0 → HALF.
    - t > HALF−1 → 2^INWD−1.
    - Otherwise HALF + t.
  - HardTanh:
    - t < −HALF → 0.
    - t > HALF−1 → 2^INWD−1.
    - Otherwise HALF + t.
- **Low-saturation event:**
  - ReLU with t < 0, or HardTanh with t < −HALF.
  - A ReLU t == 0 is not an event.
  - The high-saturation event is t > HALF−1.
- **Beat counter** (0..FOLD−1):
  - Advances on each output handshake (out_valid & out_ready).
  - Wraps to 0 after FOLD−1.
  - out_last = (count == FOLD−1) for the beat currently in S2.
  - With FOLD = 1, out_last is constantly 1 while out_valid.
- **Pipeline control:**
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en.
  - No combinational path from in_valid to out_valid.
  - The only combinational path is out_ready → in_ready.
- **Reset:** clears s1_valid, s2_valid, out_data, the beat counter and both counters to 0. Reset mid-operation drops in-flight beats.
- **Stall:** S2 contents, out_data and out_last hold stable while out_valid & !out_ready.

## Timing
- Latency is 2 cycles from input handshake to out_valid, with out_ready held high.
- Throughput is 1 beat/cycle under continuous valid/ready.
- After reset deasserts, in_ready = 1 in the first cycle.
- Full condition: both stages valid and out_ready = 0 → in_ready = 0 in that cycle.
- A simultaneous input and output handshake with both stages full is legal: everything shifts and no bubble is inserted.
- Counters update in the cycle the S2 beat handshakes out, adding that beat's per-lane event count (0..LANES).
  - They saturate at 2^CNTW−1.
  - clr_cnt has priority: the same-cycle events are not counted.

## Configuration
- `FC_ACT_SATCNT_EN` defined: the saturation counters and their event logic are built as described.
- Not defined:
  - `sat_lo_cnt` and `sat_hi_cnt` are tied to 0.
  - `clr_cnt` is ignored.
  - No counter flops are synthesised.
  - Datapath behaviour is identical.

## Test plan
All scenarios use INWD=8, DIM_IN=4, LANES=4, FOLD=2, ZP=512, shift 0 unless stated.
- **ReLU clip values:** lanes {512, 600, 700, 400}, mode 0 → {128, 216, 255, 128} two cycles later. With FEN defined, sat_lo_cnt = 1 and sat_hi_cnt = 1.
- **HardTanh clip values:** lanes {400, 300, 1023, 0}, mode 1 → {16, 0, 255, 0}.
- **Shift:** lane 700 with shift 1 → 222; lane 0 with shift 3, HardTanh → 64.
- **Backpressure and out_last:** stream 6 beats, out_ready toggling 1,0,0,1,...
  - No beat is lost or duplicated; data stays stable while stalled.
  - out_last is high on beats 2, 4 and 6.
  - in_ready is low only when both stages are full and out_ready is low.
- **Reset mid-stream:** assert reset with 2 beats in flight.
  - Next cycle: out_valid = 0 and counters are 0.
  - The first beat after reset has out_last = 0.
- **Counter saturation and clear:** with CNTW=2, drive 5 low-clip beats → sat_lo_cnt holds 3. Assert clr_cnt together with a clipping beat → sat_lo_cnt = 0.

Source files
------------

// File: rtl/fc_act_stream_if.sv
// Handshake bundle for fc_act_stream: input beat stream and output beat stream.
interface fc_act_stream_if #(
  parameter int unsigned INWD       = 8,
  parameter int unsigned LOG_DIM_IN = 2,
  parameter int unsigned LANES      = 4,
  parameter int unsigned SHW        = 3
);
  localparam int unsigned IW = INWD + LOG_DIM_IN;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IW-1:0]     in_data;
  logic                    in_mode;
  logic [SHW-1:0]          in_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*INWD-1:0]   out_data;
  logic                    out_last;

  modport master (
    output in_valid, in_data, in_mode, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fc_act_stream.sv
// Two-stage handshaked activation (zero-point removal, shift, ReLU/HardTanh clip).
// Optional saturation counters are built when FC_ACT_SATCNT_EN is defined.
module fc_act_stream #(
  parameter int unsigned INWD       = 8,
  parameter int unsigned DIM_IN     = 4,
  parameter int unsigned LOG_DIM_IN = 2,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FOLD       = 2,
  parameter int unsigned SHW        = 3,
  parameter int unsigned CNTW       = 16
) (
  input  logic              clk,
  input  logic              reset,
  fc_act_stream_if.slave    bus,
  input  logic              clr_cnt,
  output logic [CNTW-1:0]   sat_lo_cnt,
  output logic [CNTW-1:0]   sat_hi_cnt
);
  localparam int unsigned IW   = INWD + LOG_DIM_IN;
  localparam int unsigned SW   = IW + 1;
  localparam int unsigned HALF = 1 << (INWD - 1);
  localparam int unsigned ZP   = DIM_IN * HALF;
  localparam int unsigned BW   = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int          LO_I = -int'(HALF);

  localparam logic signed [SW-1:0] ZP_S   = SW'(ZP);
  localparam logic signed [SW-1:0] HI_LIM = SW'(HALF - 1);
  localparam logic signed [SW-1:0] LO_LIM = SW'(LO_I);
  localparam logic [INWD-1:0]      HALF_C = INWD'(HALF);
  localparam logic [INWD-1:0]      MAX_C  = '1;

  logic                    s1_valid, s2_valid;
  logic                    s1_en, s2_en, out_hs;
  logic                    s1_mode;
  logic signed [SW-1:0]    s1_t   [LANES];
  logic signed [SW-1:0]    s_c    [LANES];
  logic signed [SW-1:0]    t_c    [LANES];
  logic [INWD-1:0]         clip_c [LANES];
  logic [LANES-1:0]        lo_ev_c, hi_ev_c;
  logic [LANES*INWD-1:0]   out_data_q;
  logic [BW-1:0]           beat_q, beat_nxt;
  logic                    last_q;

  assign s2_en  = !s2_valid || bus.out_ready;
  assign s1_en  = !s1_valid || s2_en;
  assign out_hs = s2_valid && bus.out_ready;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = last_q;

  // Zero-point removal and flooring arithmetic shift on the incoming beat.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      s_c[j] = $signed({1'b0, bus.in_data[j*IW +: IW]}) - ZP_S;
      t_c[j] = s_c[j] >>> bus.in_shift;
    end
  end

  // Per-lane clip of the S1 value into offset-binary output codes.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      hi_ev_c[j] = s1_t[j] > HI_LIM;
      lo_ev_c[j] = s1_mode ? (s1_t[j] < LO_LIM) : s1_t[j][SW-1];
      if (hi_ev_c[j]) begin
        clip_c[j] = MAX_C;
      end else if (lo_ev_c[j]) begin
        clip_c[j] = s1_mode ? '0 : HALF_C;
      end else begin
        clip_c[j] = INWD'(s1_t[j]) + HALF_C;
      end
    end
  end

  assign beat_nxt = (beat_q == BW'(FOLD - 1)) ? '0 : beat_q + BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_mode    <= 1'b0;
      out_data_q <= '0;
      beat_q     <= '0;
      last_q     <= (FOLD == 1);
      for (int j = 0; j < LANES; j++) s1_t[j] <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_mode <= bus.in_mode;
          for (int j = 0; j < LANES; j++) s1_t[j] <= t_c[j];
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          for (int j = 0; j < LANES; j++) out_data_q[j*INWD +: INWD] <= clip_c[j];
        end
      end
      // Beat position tracks the beat now sitting in S2.
      if (out_hs) begin
        beat_q <= beat_nxt;
        last_q <= (beat_nxt == BW'(FOLD - 1));
      end
    end
  end

`ifdef FC_ACT_SATCNT_EN
  localparam int unsigned NW   = $clog2(LANES + 1);
  localparam int unsigned SUMW = ((CNTW > NW) ? CNTW : NW) + 1;

  logic [NW-1:0]   lo_n_c, hi_n_c, s2_lo_n, s2_hi_n;
  logic [CNTW-1:0] lo_cnt_q, hi_cnt_q;

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] c, input logic [NW-1:0] n);
    logic [SUMW-1:0] s;
    s = SUMW'(c) + SUMW'(n);
    if (|(s >> CNTW)) return '1;
    return CNTW'(s);
  endfunction

  always_comb begin
    lo_n_c = '0;
    hi_n_c = '0;
    for (int j = 0; j < LANES; j++) begin
      lo_n_c = lo_n_c + NW'(lo_ev_c[j]);
      hi_n_c = hi_n_c + NW'(hi_ev_c[j]);
    end
  end

  // Event counts ride with the beat through S2; counted when it leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_lo_n  <= '0;
      s2_hi_n  <= '0;
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else begin
      if (s2_en && s1_valid) begin
        s2_lo_n <= lo_n_c;
        s2_hi_n <= hi_n_c;
      end
      if (clr_cnt) begin
        lo_cnt_q <= '0;
        hi_cnt_q <= '0;
      end else if (out_hs) begin
        lo_cnt_q <= sat_add(lo_cnt_q, s2_lo_n);
        hi_cnt_q <= sat_add(hi_cnt_q, s2_hi_n);
      end
    end
  end

  assign sat_lo_cnt = lo_cnt_q;
  assign sat_hi_cnt = hi_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign sat_lo_cnt = '0;
  assign sat_hi_cnt = '0;
`endif

endmodule

// File: tb/tb_fc_act_stream.sv
// Directed self-checking bench for fc_act_stream (INWD=8, DIM_IN=4, LANES=4, FOLD=2, CNTW=2).
module tb_fc_act_stream;
  localparam int unsigned CNTW = 2;
`ifdef FC_ACT_SATCNT_EN
  localparam bit SATEN = 1'b1;
`else
  localparam bit SATEN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            clr_cnt;
  logic [CNTW-1:0] sat_lo_cnt, sat_hi_cnt;

  int checks   = 0;
  int failures = 0;
  int nbeat    = 0;

  always #5 clk = ~clk;

  fc_act_stream_if #(.INWD(8), .LOG_DIM_IN(2), .LANES(4), .SHW(3)) bus ();

  fc_act_stream #(
    .INWD(8), .DIM_IN(4), .LOG_DIM_IN(2), .LANES(4), .FOLD(2), .SHW(3), .CNTW(CNTW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .clr_cnt    (clr_cnt),
    .sat_lo_cnt (sat_lo_cnt),
    .sat_hi_cnt (sat_hi_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] lanes_in(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  function automatic logic [31:0] lanes_out(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // One beat through an idle pipeline with out_ready high; optional clr_cnt on its exit cycle.
  task automatic beat(input string tag, input logic [39:0] d, input logic m, input logic [2:0] sh,
                      input logic [31:0] exp, input logic clr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_shift = sh;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    clr_cnt = clr;
    @(negedge clk);
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, ".out_data"}, 64'(bus.out_data), 64'(exp));
    check({tag, ".out_last"}, 64'(bus.out_last), 64'(nbeat % 2 == 1));
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    nbeat++;
  endtask

  task automatic check_cnt(input string tag, input int lo, input int hi);
    check({tag, ".sat_lo"}, 64'(sat_lo_cnt), SATEN ? 64'(lo) : 64'(0));
    check({tag, ".sat_hi"}, 64'(sat_hi_cnt), SATEN ? 64'(hi) : 64'(0));
  endtask

  initial begin
    int sent, rcv, cyc, occ;
    logic stall_prev, last_prev, in_hs, out_hs;
    logic [31:0] data_prev;

    reset = 1'b1;
    clr_cnt = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mode = 1'b0;
    bus.in_shift = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.in_ready", 64'(bus.in_ready), 64'(1));
    check("rst.out_valid", 64'(bus.out_valid), 64'(0));
    check("rst.out_data", 64'(bus.out_data), 64'(0));
    check_cnt("rst", 0, 0);
    @(posedge clk); #1;

    beat("relu", lanes_in(512, 600, 700, 400), 1'b0, 3'd0, lanes_out(128, 216, 255, 128), 1'b0);
    check_cnt("relu", 1, 1);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check_cnt("clr_idle", 0, 0);

    beat("htanh", lanes_in(400, 300, 1023, 0), 1'b1, 3'd0, lanes_out(16, 0, 255, 0), 1'b0);
    check_cnt("htanh", 2, 1);
    beat("shr1", lanes_in(700, 512, 600, 400), 1'b0, 3'd1, lanes_out(222, 128, 172, 128), 1'b0);
    check_cnt("shr1", 3, 1);
    beat("shr3", lanes_in(0, 1023, 512, 300), 1'b1, 3'd3, lanes_out(64, 191, 128, 101), 1'b0);
    check_cnt("shr3", 3, 1);

    // Six beats against out_ready pattern 1,0,0 repeating.
    sent = 0; rcv = 0; cyc = 0;
    stall_prev = 1'b0; last_prev = 1'b0; data_prev = '0;
    while (rcv < 6 && cyc < 60) begin
      bus.out_ready = (cyc % 3 == 0);
      bus.in_valid  = (sent < 6);
      bus.in_data   = lanes_in(512 + 10*sent, 512 + 10*sent, 512 + 10*sent, 512 + 10*sent);
      bus.in_mode   = 1'b0;
      bus.in_shift  = '0;
      #1;
      occ = sent - rcv;
      check("bp.in_ready", 64'(bus.in_ready), 64'(!(occ == 2 && !bus.out_ready)));
      if (stall_prev) begin
        check("bp.hold_valid", 64'(bus.out_valid), 64'(1));
        check("bp.hold_data", 64'(bus.out_data), 64'(data_prev));
        check("bp.hold_last", 64'(bus.out_last), 64'(last_prev));
      end
      in_hs  = bus.in_valid && bus.in_ready;
      out_hs = bus.out_valid && bus.out_ready;
      if (out_hs) begin
        check("bp.data", 64'(bus.out_data),
              64'(lanes_out(128 + 10*rcv, 128 + 10*rcv, 128 + 10*rcv, 128 + 10*rcv)));
        check("bp.last", 64'(bus.out_last), 64'(nbeat % 2 == 1));
        nbeat++;
        rcv++;
      end
      if (in_hs) sent++;
      stall_prev = bus.out_valid && !bus.out_ready;
      data_prev  = bus.out_data;
      last_prev  = bus.out_last;
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp.received", 64'(rcv), 64'(6));

    // Leave the beat counter mid-vector, then reset with two beats in flight.
    beat("pre", lanes_in(512, 512, 512, 512), 1'b0, 3'd0, lanes_out(128, 128, 128, 128), 1'b0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = lanes_in(600, 600, 600, 600);
    @(negedge clk);
    check("fill.in_ready0", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("fill.in_ready1", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full.out_valid", 64'(bus.out_valid), 64'(1));
    check("full.in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nbeat = 0;
    @(negedge clk);
    check("midrst.out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst.in_ready", 64'(bus.in_ready), 64'(1));
    check_cnt("midrst", 0, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst.no_ghost", 64'(bus.out_valid), 64'(0));
    beat("post", lanes_in(512, 600, 512, 512), 1'b0, 3'd0, lanes_out(128, 216, 128, 128), 1'b0);

    for (int i = 0; i < 5; i++)
      beat("satlo", lanes_in(400, 512, 512, 512), 1'b0, 3'd0, lanes_out(128, 128, 128, 128), 1'b0);
    check_cnt("sat", 3, 0);
    beat("clrbeat", lanes_in(400, 512, 512, 512), 1'b0, 3'd0, lanes_out(128, 128, 128, 128), 1'b1);
    check_cnt("clrbeat", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
